// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared size codes, AXI response codes and FSM states for the load/store unit
package lsu_pkg;

  localparam logic [1:0] LSU_B = 2'b00;
  localparam logic [1:0] LSU_H = 2'b01;
  localparam logic [1:0] LSU_W = 2'b10;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WRESP,
    ST_RADDR,
    ST_RDATA
  } lsu_state_t;

endpackage

// File: rtl/lsu_data_align.sv
// rtl/lsu_data_align.sv - byte-lane strobes, store replication, misalign decode and load extension
module lsu_data_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic        misalign,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  // Store lane selection; size 2'b11 has no legal encoding and is dropped as misaligned
  always_comb begin
    wstrb     = 4'b0000;
    wdata_rep = wdata;
    misalign  = 1'b0;
    case (size)
      LSU_B: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      LSU_H: begin
        wstrb     = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        misalign  = addr_lo[0];
      end
      LSU_W: begin
        wstrb    = 4'b1111;
        misalign = (addr_lo != 2'b00);
      end
      default: misalign = 1'b1;
    endcase
  end

  // Load lane extraction: shift addressed byte/half down, then sign- or zero-extend
  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    case (size)
      LSU_B:   rdata_ext = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      LSU_H:   rdata_ext = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      default: rdata_ext = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_axil_master.sv
// rtl/lsu_axil_master.sv - MEM-stage load/store unit as AXI4-Lite master; LSU_POSTED_WR_EN releases stores before B
module lsu_axil_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              dmem_rd_en_i,
  input  logic              dmem_wr_en_i,
  input  logic [2:0]        func3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              stall_o,
  output logic [31:0]       rdata_o,
  output logic              rdata_valid_o,
  output logic              misalign_o,
  output logic              bus_err_o,
  output logic [ADDR_W-1:0] m_awaddr_o,
  output logic [2:0]        m_awprot_o,
  output logic              m_awvalid_o,
  input  logic              m_awready_i,
  output logic [DATA_W-1:0] m_wdata_o,
  output logic [3:0]        m_wstrb_o,
  output logic              m_wvalid_o,
  input  logic              m_wready_i,
  input  logic [1:0]        m_bresp_i,
  input  logic              m_bvalid_i,
  output logic              m_bready_o,
  output logic [ADDR_W-1:0] m_araddr_o,
  output logic [2:0]        m_arprot_o,
  output logic              m_arvalid_o,
  input  logic              m_arready_i,
  input  logic [DATA_W-1:0] m_rdata_i,
  input  logic [1:0]        m_rresp_i,
  input  logic              m_rvalid_i,
  output logic              m_rready_o
);

  if (DATA_W != 32) begin : g_data_w_check
    $error("lsu_axil_master: DATA_W must be 32");
  end

  lsu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              aw_done_q, w_done_q;
  logic              b_pending_q;

  logic        in_idle, req, can_accept, accept, drop_misalign;
  logic        aw_fire, w_fire, ar_fire, r_fire, b_fire, wr_both;
  logic [1:0]  al_addr, al_size;
  logic        al_uns, al_misalign;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata, al_rdata;

  assign in_idle = (state_q == ST_IDLE);
  assign req     = dmem_rd_en_i | dmem_wr_en_i;

  // Live request decode in IDLE, registered access shape while the load is in flight
  assign al_addr = in_idle ? addr_i[1:0]  : addr_q[1:0];
  assign al_size = in_idle ? func3_i[1:0] : size_q;
  assign al_uns  = in_idle ? func3_i[2]   : uns_q;

  lsu_data_align u_align (
    .addr_lo     (al_addr),
    .size        (al_size),
    .is_unsigned (al_uns),
    .wdata       (wdata_i),
    .rdata       (m_rdata_i),
    .wstrb       (al_wstrb),
    .wdata_rep   (al_wdata),
    .misalign    (al_misalign),
    .rdata_ext   (al_rdata)
  );

  assign m_awaddr_o  = addr_q;
  assign m_araddr_o  = addr_q;
  assign m_awprot_o  = 3'b000;
  assign m_arprot_o  = 3'b000;
  assign m_wdata_o   = wdata_q;
  assign m_wstrb_o   = wstrb_q;
  assign m_awvalid_o = (state_q == ST_WRITE) & ~aw_done_q;
  assign m_wvalid_o  = (state_q == ST_WRITE) & ~w_done_q;
  assign m_arvalid_o = (state_q == ST_RADDR);
  assign m_rready_o  = (state_q == ST_RDATA);
  assign m_bready_o  = (state_q == ST_WRESP) | b_pending_q;

  assign aw_fire = m_awvalid_o & m_awready_i;
  assign w_fire  = m_wvalid_o  & m_wready_i;
  assign ar_fire = m_arvalid_o & m_arready_i;
  assign r_fire  = m_rready_o  & m_rvalid_i;
  assign b_fire  = m_bready_o  & m_bvalid_i;
  assign wr_both = (aw_done_q | aw_fire) & (w_done_q | w_fire);

`ifdef LSU_POSTED_WR_EN
  assign can_accept = ~b_pending_q;
`else
  assign can_accept = 1'b1;
`endif

  assign accept        = in_idle & req & can_accept & ~al_misalign;
  assign drop_misalign = in_idle & req & can_accept &  al_misalign;

  // Next-state and stall; stall drops in the cycle the final handshake completes
  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          stall_o = 1'b1;
          state_d = dmem_wr_en_i ? ST_WRITE : ST_RADDR;
        end else if (req & ~can_accept) begin
          stall_o = 1'b1;
        end
      end
      ST_WRITE: begin
`ifdef LSU_POSTED_WR_EN
        stall_o = ~wr_both;
        if (wr_both) state_d = ST_IDLE;
`else
        stall_o = 1'b1;
        if (wr_both) state_d = ST_WRESP;
`endif
      end
      ST_WRESP: begin
        stall_o = ~b_fire;
        if (b_fire) state_d = ST_IDLE;
      end
      ST_RADDR: begin
        stall_o = 1'b1;
        if (ar_fire) state_d = ST_RDATA;
      end
      ST_RDATA: begin
        stall_o = ~r_fire;
        if (r_fire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset abandons any in-flight transaction
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Request capture and per-channel write handshake tracking
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      size_q    <= LSU_W;
      uns_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else if (accept) begin
      addr_q    <= addr_i;
      wdata_q   <= al_wdata;
      wstrb_q   <= al_wstrb;
      size_q    <= func3_i[1:0];
      uns_q     <= func3_i[2];
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (aw_fire) aw_done_q <= 1'b1;
      if (w_fire)  w_done_q  <= 1'b1;
    end
  end

  // Write response still owed to the bus after a posted store released the pipeline
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      b_pending_q <= 1'b0;
    end else begin
`ifdef LSU_POSTED_WR_EN
      if ((state_q == ST_WRITE) && wr_both) b_pending_q <= 1'b1;
      else if (b_fire)                      b_pending_q <= 1'b0;
`else
      b_pending_q <= 1'b0;
`endif
    end
  end

  // One-cycle completion pulses and the load result held for WB
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_o       <= '0;
      rdata_valid_o <= 1'b0;
      misalign_o    <= 1'b0;
      bus_err_o     <= 1'b0;
    end else begin
      rdata_valid_o <= r_fire;
      misalign_o    <= drop_misalign;
      bus_err_o     <= (r_fire & (m_rresp_i != AXI_OKAY)) | (b_fire & (m_bresp_i != AXI_OKAY));
      if (r_fire) rdata_o <= (m_rresp_i == AXI_OKAY) ? al_rdata : 32'h0;
    end
  end

`ifndef SYNTHESIS
  // Decoder must never raise load and store together
  always_ff @(posedge clk_i) begin
    if (rst_ni && in_idle)
      assert (!(dmem_rd_en_i && dmem_wr_en_i))
        else $error("lsu_axil_master: simultaneous load and store request");
  end
`endif

endmodule

// File: tb/tb_lsu_axil_master.sv
// tb/tb_lsu_axil_master.sv - scoreboard bench for lsu_axil_master against a configurable AXI4-Lite slave
module tb_lsu_axil_master;

  logic        clk, rst_n;
  logic        dmem_rd_en, dmem_wr_en;
  logic [2:0]  func3;
  logic [31:0] addr, wdata;
  logic        stall_o, rdata_valid_o, misalign_o, bus_err_o;
  logic [31:0] rdata_o;
  logic [31:0] m_awaddr_o, m_araddr_o, m_wdata_o;
  logic [2:0]  m_awprot_o, m_arprot_o;
  logic        m_awvalid_o, m_awready_i, m_wvalid_o, m_wready_i;
  logic [3:0]  m_wstrb_o;
  logic [1:0]  m_bresp_i, m_rresp_i;
  logic        m_bvalid_i, m_bready_o, m_arvalid_o, m_arready_i;
  logic [31:0] m_rdata_i;
  logic        m_rvalid_i, m_rready_o;

  lsu_axil_master dut (
    .clk_i(clk), .rst_ni(rst_n),
    .dmem_rd_en_i(dmem_rd_en), .dmem_wr_en_i(dmem_wr_en),
    .func3_i(func3), .addr_i(addr), .wdata_i(wdata),
    .stall_o(stall_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o),
    .m_awaddr_o(m_awaddr_o), .m_awprot_o(m_awprot_o), .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
    .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o), .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i),
    .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o),
    .m_araddr_o(m_araddr_o), .m_arprot_o(m_arprot_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
    .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i), .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic        mis;
    logic        err;
    logic [31:0] data;
  } out_t;

  out_t        exp_out[$];
  logic [31:0] exp_ar[$];
  logic [31:0] exp_aw[$];
  logic [35:0] exp_w[$];

  int checks = 0;
  int errors = 0;
  int b_count = 0;

  int          aw_wait = 0, w_wait = 0, ar_wait = 0;
  logic [31:0] s_rdata = 32'h0;
  logic [1:0]  s_rresp = 2'b00, s_bresp = 2'b00;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT event with no expected entry", name);
  endtask

  // Slave: each ready rises after a programmable number of valid cycles; R/B answer as soon as ready is seen
  initial begin
    int aw_cnt, w_cnt, ar_cnt;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
    m_awready_i = 0; m_wready_i = 0; m_arready_i = 0;
    m_rvalid_i = 0; m_bvalid_i = 0; m_rdata_i = 0; m_rresp_i = 0; m_bresp_i = 0;
    forever begin
      @(negedge clk);
      if (m_awvalid_o) begin m_awready_i = (aw_cnt >= aw_wait); aw_cnt++; end
      else begin m_awready_i = 0; aw_cnt = 0; end
      if (m_wvalid_o) begin m_wready_i = (w_cnt >= w_wait); w_cnt++; end
      else begin m_wready_i = 0; w_cnt = 0; end
      if (m_arvalid_o) begin m_arready_i = (ar_cnt >= ar_wait); ar_cnt++; end
      else begin m_arready_i = 0; ar_cnt = 0; end
      m_rvalid_i = m_rready_o;
      m_rdata_i  = s_rdata;
      m_rresp_i  = s_rresp;
      m_bvalid_i = m_bready_o;
      m_bresp_i  = s_bresp;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT completes a handshake or pulses a result
  initial begin
    out_t e;
    forever begin
      @(negedge clk);
      #2;
      if (m_arvalid_o && m_arready_i) begin
        if (exp_ar.size() == 0) unexpected("ar_handshake");
        else chk("ar_addr", 36'(m_araddr_o), 36'(exp_ar.pop_front()));
      end
      if (m_awvalid_o && m_awready_i) begin
        if (exp_aw.size() == 0) unexpected("aw_handshake");
        else chk("aw_addr", 36'(m_awaddr_o), 36'(exp_aw.pop_front()));
      end
      if (m_wvalid_o && m_wready_i) begin
        if (exp_w.size() == 0) unexpected("w_handshake");
        else chk("w_strb_data", {m_wstrb_o, m_wdata_o}, exp_w.pop_front());
      end
      if (m_bvalid_i && m_bready_o) b_count++;
      if (rdata_valid_o || misalign_o || bus_err_o) begin
        if (exp_out.size() == 0) unexpected("result_pulse");
        else begin
          e = exp_out.pop_front();
          chk("rdata_valid", 36'(rdata_valid_o), 36'(e.rv));
          chk("misalign", 36'(misalign_o), 36'(e.mis));
          chk("bus_err", 36'(bus_err_o), 36'(e.err));
          if (e.rv) chk("rdata", 36'(rdata_o), 36'(e.data));
        end
      end
    end
  end

  // Pipeline model: present a request and hold it until stall_o releases; returns cycles occupied
  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, output int cyc);
    @(negedge clk);
    dmem_rd_en = rd; dmem_wr_en = wr; func3 = f3; addr = a; wdata = wd;
    cyc = 0;
    while (1) begin
      #1;
      cyc++;
      if (!stall_o) break;
      if (cyc >= 60) begin
        checks++; errors++;
        $display("FAIL stall_timeout: stall_o still 1 after %0d cycles, required release", cyc);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    dmem_rd_en = 0; dmem_wr_en = 0;
  endtask

  function automatic out_t mk(input logic rv, input logic mis, input logic err, input logic [31:0] d);
    out_t o;
    o.rv = rv; o.mis = mis; o.err = err; o.data = d;
    return o;
  endfunction

  initial begin
    int cyc, b_before;
    rst_n = 0; dmem_rd_en = 0; dmem_wr_en = 0; func3 = 0; addr = 0; wdata = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", 36'(stall_o), 36'(0));
    chk("rst_valids", 36'({m_awvalid_o, m_wvalid_o, m_arvalid_o, m_bready_o, m_rready_o}), 36'(0));
    chk("rst_pulses", 36'({rdata_valid_o, misalign_o, bus_err_o}), 36'(0));
    chk("rst_rdata", 36'(rdata_o), 36'(0));
    rst_n = 1;

    // LW 0x100 zero-wait
    s_rdata = 32'hDEADBEEF;
    exp_ar.push_back(32'h100); exp_out.push_back(mk(1, 0, 0, 32'hDEADBEEF));
    issue(1, 0, 3'b010, 32'h100, 0, cyc);
    chk("lw_cycles", 36'(cyc), 36'(3));

    // LB / LBU at 0x103, top byte 0x80
    s_rdata = 32'h80123456;
    exp_ar.push_back(32'h103); exp_out.push_back(mk(1, 0, 0, 32'hFFFFFF80));
    issue(1, 0, 3'b000, 32'h103, 0, cyc);
    exp_ar.push_back(32'h103); exp_out.push_back(mk(1, 0, 0, 32'h00000080));
    issue(1, 0, 3'b100, 32'h103, 0, cyc);

    // LH / LHU at 0x102, upper half 0x9ABC
    s_rdata = 32'h9ABC1234;
    exp_ar.push_back(32'h102); exp_out.push_back(mk(1, 0, 0, 32'hFFFF9ABC));
    issue(1, 0, 3'b001, 32'h102, 0, cyc);
    exp_ar.push_back(32'h102); exp_out.push_back(mk(1, 0, 0, 32'h00009ABC));
    issue(1, 0, 3'b101, 32'h102, 0, cyc);

    // SH 0x202 and SB 0x201 with zero-wait slave
    exp_aw.push_back(32'h202); exp_w.push_back({4'b1100, 32'hABCDABCD});
    issue(0, 1, 3'b001, 32'h202, 32'h1234ABCD, cyc);
    chk("sh_cycles", 36'(cyc), 36'(3));
    exp_aw.push_back(32'h201); exp_w.push_back({4'b0010, 32'h55555555});
    issue(0, 1, 3'b000, 32'h201, 32'h00000055, cyc);

    // SW 0x300: W accepted three cycles before AW
    aw_wait = 3; w_wait = 0;
    b_before = b_count;
    exp_aw.push_back(32'h300); exp_w.push_back({4'b1111, 32'hCAFEF00D});
    issue(0, 1, 3'b010, 32'h300, 32'hCAFEF00D, cyc);
    chk("sw_wait_cycles", 36'(cyc), 36'(6));
    chk("sw_b_count", 36'(b_count - b_before), 36'(1));
    aw_wait = 0;

    // Misaligned accesses: SW 0x301, LH 0x101, size 2'b11
    exp_out.push_back(mk(0, 1, 0, 0));
    issue(0, 1, 3'b010, 32'h301, 32'h0, cyc);
    chk("mis_sw_cycles", 36'(cyc), 36'(1));
    chk("mis_no_valid", 36'({m_awvalid_o, m_wvalid_o, m_arvalid_o}), 36'(0));
    exp_out.push_back(mk(0, 1, 0, 0));
    issue(1, 0, 3'b001, 32'h101, 0, cyc);
    exp_out.push_back(mk(0, 1, 0, 0));
    issue(1, 0, 3'b011, 32'h100, 0, cyc);

    // LW with SLVERR read response
    s_rdata = 32'hFFFFFFFF; s_rresp = 2'b10;
    exp_ar.push_back(32'h104); exp_out.push_back(mk(1, 0, 1, 32'h0));
    issue(1, 0, 3'b010, 32'h104, 0, cyc);
    s_rresp = 2'b00;

    // SW with SLVERR write response
    s_bresp = 2'b10;
    exp_aw.push_back(32'h400); exp_w.push_back({4'b1111, 32'h11223344});
    exp_out.push_back(mk(0, 0, 1, 0));
    issue(0, 1, 3'b010, 32'h400, 32'h11223344, cyc);
    s_bresp = 2'b00;

    // Reset while the AR channel is stalled
    ar_wait = 100;
    @(negedge clk);
    dmem_rd_en = 1; func3 = 3'b010; addr = 32'h600;
    @(negedge clk);
    #1;
    chk("raddr_arvalid", 36'(m_arvalid_o), 36'(1));
    @(negedge clk);
    #1;
    rst_n = 0; dmem_rd_en = 0;
    #1;
    chk("rst_arvalid", 36'(m_arvalid_o), 36'(0));
    @(negedge clk);
    rst_n = 1; ar_wait = 0;
    @(negedge clk);
    #1;
    chk("post_rst_stall", 36'(stall_o), 36'(0));

    s_rdata = 32'h0BADF00D;
    exp_ar.push_back(32'h500); exp_out.push_back(mk(1, 0, 0, 32'h0BADF00D));
    issue(1, 0, 3'b010, 32'h500, 0, cyc);
    chk("post_rst_lw_cycles", 36'(cyc), 36'(3));

    repeat (4) @(negedge clk);
    #3;
    chk("scoreboard_drained", 36'(exp_out.size() + exp_ar.size() + exp_aw.size() + exp_w.size()), 36'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu_axil_master.md
Name: lsu_axil_master

Overview:
- Load/store unit for the 5-stage RV32I pipeline.
- Consumes the MEM-stage decoded memory controls (read enable, write enable, func3 size/sign, ALU address, rs2 data) and drives them as single-beat AXI4-Lite master transactions. It replaces the temporary direct DMEM enables.
- Stalls the pipeline while a transaction is outstanding.
- Returns aligned, size/sign-extended load data to WB.

Parameters:
- ADDR_W, 32, AXI address width; the low 2 bits are used for byte lanes.
- DATA_W, 32, fixed data width; only 32 is supported and elaboration errors otherwise.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- dmem_rd_en_i  in  1  load request (MEM stage)
- dmem_wr_en_i  in  1  store request (MEM stage)
- func3_i  in  3  [1:0] size (00 B, 01 H, 10 W); [2]=1 unsigned load
- addr_i  in  ADDR_W  effective address from ALU
- wdata_i  in  32  rs2 store data
- stall_o  out  1  freeze IF..MEM
- rdata_o  out  32  extended load result for WB
- rdata_valid_o  out  1  one-cycle pulse, rdata_o updated
- misalign_o  out  1  one-cycle pulse, misaligned access dropped
- bus_err_o  out  1  one-cycle pulse, non-OKAY response
- m_awaddr_o/m_awvalid_o/m_awready_i, m_wdata_o/m_wstrb_o(4)/m_wvalid_o/m_wready_i, m_bresp_i(2)/m_bvalid_i/m_bready_o, m_araddr_o/m_arvalid_o/m_arready_i, m_rdata_i/m_rresp_i(2)/m_rvalid_i/m_rready_o: AXI4-Lite master; AxPROT tied 3'b000.

Behaviour:
- Reset (async, rst_ni=0):
  - State goes to IDLE.
  - All AXI valids, m_bready_o, m_rready_o, rdata_valid_o, misalign_o and bus_err_o are 0; rdata_o is 0.
  - An in-flight transaction is abandoned; the interconnect shares the same reset.
- State machine: IDLE, WRITE (AW/W), WRESP, RADDR, RDATA.
- IDLE, request present and aligned:
  - Register addr, strobe, replicated wdata, size and sign.
  - Load goes to RADDR; store goes to WRITE.
  - stall_o=1 combinationally in this same cycle.
- Simultaneous rd_en and wr_en: illegal. The store takes priority; flag with a simulation assertion.
- WRITE:
  - m_awvalid_o and m_wvalid_o assert together, registered, from the cycle after acceptance.
  - Each valid drops independently on its own handshake; either order is accepted.
  - When both handshakes are done, go to WRESP.
- WRESP: m_bready_o=1. On the B handshake go to IDLE; stall_o=0 in that cycle; bus_err_o pulses next cycle if bresp != 00.
- RADDR: m_arvalid_o=1 until m_arready_i, then go to RDATA.
- RDATA:
  - m_rready_o=1.
  - On the R handshake go to IDLE with stall_o=0 in that cycle.
  - The next cycle rdata_o holds the extracted data and rdata_valid_o=1.
  - If rresp != 00, rdata_o=0 and bus_err_o=1.
- Valids are never withdrawn before their handshake; addr/data stay stable while valid.
- Minimum latency with zero-wait slave: load = 3 cycles of stall (accept, AR, R); store = 3 (accept, AW+W, B).
- stall_o = (IDLE & request & aligned) | (state!=IDLE & !completing_handshake).
- Store strobe: B 4'b0001<<addr[1:0]; H 4'b0011<<{addr[1],1'b0}; W 4'b1111.
- Store data replication: B {4{wdata[7:0]}}; H {2{wdata[15:0]}}.
- Load extract: rdata>>(8*addr[1:0]), then zero-extend if func3[2] else sign-extend from bit 7/15.
- Misaligned (H with addr[0]=1; W with addr[1:0]!=0):
  - No AXI traffic.
  - misalign_o pulses next cycle.
  - stall_o stays 0.
- Size 2'b11: treated as misaligned.
- Requests are sampled only in IDLE. The pipeline holds its inputs during stall, and the unit ignores them while busy.

Optional Feature:
- Macro LSU_POSTED_WR_EN.
- Defined:
  - Stores release stall_o in the cycle both AW and W complete; B is consumed in the background by a pending flag.
  - A following request is accepted in IDLE only once the pending B has returned; until then stall_o=1.
  - bus_err_o reports bresp when B arrives.
- Undefined: store stall covers the full B response as described above.

Decomposition:
- lsu_pkg holds:
  - size localparams (LSU_B=2'b00, LSU_H=2'b01, LSU_W=2'b10)
  - AXI resp constants (AXI_OKAY=2'b00, AXI_SLVERR=2'b10)
  - state enum lsu_state_t
- Sub-module lsu_data_align (combinational): takes addr[1:0], size and sign. It produces wstrb, replicated wdata, misalign flag and extended load data.
- The FSM and AXI registers stay in lsu_axil_master.

Test Plan:
- LW addr 0x100, zero-wait slave returning 0xDEADBEEF -> stall_o high 3 cycles, m_araddr_o=0x100, rdata_o=0xDEADBEEF with rdata_valid_o the next cycle.
- LB addr 0x103, rdata 0x80xxxxxx -> rdata_o=0xFFFFFF80; LBU same -> 0x00000080.
- SH addr 0x202, wdata 0x1234ABCD -> m_wstrb_o=4'b1100, m_wdata_o=0xABCDABCD.
- Slave asserts m_wready_i 3 cycles before m_awready_i -> both handshakes complete, single B, stall released in the B cycle.
- SW addr 0x301 -> no AXI valids, misalign_o one pulse, stall_o=0; LW with rresp=2'b10 -> bus_err_o=1, rdata_o=0.
- rst_ni low while m_arvalid_o=1 in RADDR -> m_arvalid_o=0 immediately; stall_o=0 after release; next LW proceeds normally.
